full_adder_top: RTL and testbench



---
 rtl/full_adder_top.sv | 86 ++++++++
 tb/tb_full_adder_top.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/full_adder_top.sv
// -----------------------------------------------------------------------------
// full_adder_top
//
// Registered ripple-carry adder. Computes {Cout, S} = A + B + Cin over WIDTH
// bits through a chain of WIDTH 1-bit full-adder cells. The result is captured
// on the rising clk edge where in_valid is high, so it appears exactly one
// cycle later. There is no combinational path from any input to any output.
//
// Parameters:
//   WIDTH      operand/sum width in bits, legal range 1..64 (default 1)
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   rst        in   synchronous, active-high reset (wins over in_valid)
//   in_valid   in   A/B/Cin are valid this cycle
//   A, B       in   WIDTH-bit unsigned operands
//   Cin        in   carry into bit 0
//   out_valid  out  S/Cout hold a result captured on the previous edge
//   S          out  registered WIDTH-bit sum
//   Cout       out  registered carry out of bit WIDTH-1
//   ovf        out  registered two's-complement overflow
//                   (present only when FULL_ADDER_TOP_OVF_EN is defined)
//
// Build option:
//   FULL_ADDER_TOP_OVF_EN  adds the ovf output and its register.
// -----------------------------------------------------------------------------
module full_adder_top #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef FULL_ADDER_TOP_OVF_EN
    ,
    output logic             ovf
`endif
);

    // carry[i] is the carry into cell i; carry[0] is Cin, carry[WIDTH] is Cout.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = Cin;

    // One full-adder cell per bit. The carry term uses the propagate form
    // (c AND (a XOR b)) so the XOR is shared with the sum.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic prop;
        assign prop       = A[i] ^ B[i];
        assign sum[i]     = prop ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & prop);
    end

    // Output registers. Result registers load only on a valid input so they
    // hold their last value while idle; X on idle inputs never reaches them.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
`ifdef FULL_ADDER_TOP_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= sum;
                Cout <= carry[WIDTH];
`ifdef FULL_ADDER_TOP_OVF_EN
                // Signed overflow: carry into the sign bit differs from the
                // carry out of it. For WIDTH=1 carry[0] is Cin.
                ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_full_adder_top.sv
// -----------------------------------------------------------------------------
// tb_full_adder_top
//
// Directed, self-checking bench for full_adder_top. Three instances cover
// WIDTH=1, 4 and 8 with a shared clock and reset. Expected values are
// hand-computed constants. Inputs are driven and outputs sampled 1 ns after
// the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_full_adder_top;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    // WIDTH=1 instance
    logic       v1, a1, b1, c1, ov1, s1, co1;
    // WIDTH=4 instance
    logic       v4, c4, ov4, co4;
    logic [3:0] a4, b4, s4;
    // WIDTH=8 instance
    logic       v8, c8, ov8, co8;
    logic [7:0] a8, b8, s8;
`ifdef FULL_ADDER_TOP_OVF_EN
    logic       f1, f4, f8;
`endif

    full_adder_top #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
        .out_valid(ov1), .S(s1), .Cout(co1)
`ifdef FULL_ADDER_TOP_OVF_EN
        , .ovf(f1)
`endif
    );

    full_adder_top #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4), .Cin(c4),
        .out_valid(ov4), .S(s4), .Cout(co4)
`ifdef FULL_ADDER_TOP_OVF_EN
        , .ovf(f4)
`endif
    );

    full_adder_top #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Cin(c8),
        .out_valid(ov8), .S(s8), .Cout(co8)
`ifdef FULL_ADDER_TOP_OVF_EN
        , .ovf(f8)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed {Cout,S} for {A,B,Cin} = 000..111 at WIDTH=1.
    logic [1:0] w1_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v4 = 1'b0; a4 = '0;   b4 = '0;   c4 = 1'b0;
        v8 = 1'b0; a8 = '0;   b8 = '0;   c8 = 1'b0;

        // Reset state, {out_valid, Cout, S}
        tick(); tick();
        check("rst_w1", {13'd0, ov1, co1, s1}, 16'h0);
        check("rst_w4", {10'd0, ov4, co4, s4}, 16'h0);
        check("rst_w8", {6'd0,  ov8, co8, s8}, 16'h0);
        rst = 1'b0;

        // WIDTH=1 truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            v1 = 1'b1;
            {a1, b1, c1} = 3'(i);
            tick();
            check($sformatf("w1_vec%0d", i), {13'd0, ov1, co1, s1}, {13'd0, 1'b1, w1_exp[i]});
        end

        // Hold: one valid 1+0+0, then three idle cycles with changing/X inputs
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        tick();
        check("hold_load", {13'd0, ov1, co1, s1}, 16'b101);
        v1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
            end
            tick();
            check($sformatf("hold_idle%0d", i), {13'd0, ov1, co1, s1}, 16'b001);
        end

        // Reset wins over a simultaneous valid input
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; rst = 1'b1;
        tick();
        check("rst_prio", {13'd0, ov1, co1, s1}, 16'h0);
        rst = 1'b0; v1 = 1'b0;
        tick(); tick();
        check("rst_after", {13'd0, ov1, co1, s1}, 16'h0);

        // Result just captured is discarded by a following reset
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        tick();
        check("pend_load", {13'd0, ov1, co1, s1}, 16'b110);
        v1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("pend_drop", {13'd0, ov1, co1, s1}, 16'h0);

        // WIDTH=4 extremes
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        tick();
        check("w4_ffc", {10'd0, ov4, co4, s4}, {10'd0, 1'b1, 1'b1, 4'hF});
        a4 = 4'h8; b4 = 4'h8; c4 = 1'b0;
        tick();
        check("w4_880", {10'd0, ov4, co4, s4}, {10'd0, 1'b1, 1'b1, 4'h0});
        a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
        tick();
        check("w4_zero", {10'd0, ov4, co4, s4}, {10'd0, 1'b1, 1'b0, 4'h0});
        v4 = 1'b0;

        // WIDTH=8 back-to-back stream
        v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
        tick();
        check("w8_b2b0", {6'd0, ov8, co8, s8}, {6'd0, 1'b1, 1'b0, 8'h02});
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
        tick();
        check("w8_b2b1", {6'd0, ov8, co8, s8}, {6'd0, 1'b1, 1'b1, 8'h00});
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        tick();
        check("w8_b2b2", {6'd0, ov8, co8, s8}, {6'd0, 1'b1, 1'b1, 8'h00});
        v8 = 1'b0; a8 = 8'h55; b8 = 8'h11;
        tick();
        check("w8_idle", {6'd0, ov8, co8, s8}, {6'd0, 1'b0, 1'b1, 8'h00});

`ifdef FULL_ADDER_TOP_OVF_EN
        // Signed overflow, WIDTH=4: {ovf, out_valid, Cout, S}
        v4 = 1'b1; a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
        tick();
        check("ovf_71", {9'd0, f4, ov4, co4, s4}, {9'd0, 1'b1, 1'b1, 1'b0, 4'h8});
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b0;
        tick();
        check("ovf_f1", {9'd0, f4, ov4, co4, s4}, {9'd0, 1'b0, 1'b1, 1'b1, 4'h0});
        a4 = 4'h8; b4 = 4'h8; c4 = 1'b0;
        tick();
        check("ovf_88", {9'd0, f4, ov4, co4, s4}, {9'd0, 1'b1, 1'b1, 1'b1, 4'h0});
        v4 = 1'b0;
        tick();
        check("ovf_hold", {15'd0, f4}, 16'h1);
        // WIDTH=1: 0+0+1 -> c1=0, c0=1 -> overflow
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
        tick();
        check("ovf_w1", {15'd0, f1}, 16'h1);
        v1 = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
